// File: rtl/rob_dual_commit.sv
// Reorder buffer with an explicit occupancy counter and up to two in-order commits per cycle.
// Branches resolve at the head; a mispredict flushes the whole buffer and redirects fetch.
module rob_dual_commit #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned NWB   = 3,
    parameter int unsigned XLEN  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  alloc_valid,
    input  logic [1:0]            alloc_kind,
    input  logic [4:0]            alloc_rd,
    input  logic [XLEN-1:0]       alloc_imm,
    input  logic [XLEN-1:0]       alloc_pc,
    input  logic                  alloc_pred,
    input  logic                  alloc_is_c,
    output logic                  rob_full,
    output logic [IDX_W-1:0]      rob_free_id,
    output logic [IDX_W-1:0]      rob_head,
    input  logic [IDX_W-1:0]      q1_id,
    input  logic [IDX_W-1:0]      q2_id,
    output logic                  q1_ready,
    output logic                  q2_ready,
    output logic [XLEN-1:0]       q1_value,
    output logic [XLEN-1:0]       q2_value,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [NWB*IDX_W-1:0]  wb_id,
    input  logic [NWB*XLEN-1:0]   wb_value,
    input  logic [XLEN-1:0]       wb_target,
    output logic [1:0]            cm_en,
    output logic [4:0]            cm_rd0,
    output logic [4:0]            cm_rd1,
    output logic [IDX_W-1:0]      cm_id0,
    output logic [IDX_W-1:0]      cm_id1,
    output logic [XLEN-1:0]       cm_val0,
    output logic [XLEN-1:0]       cm_val1,
    output logic                  jalr_finish,
    output logic                  branch_finish,
    output logic [XLEN-1:0]       pc_next,
    output logic [XLEN-1:0]       pc_branch,
    output logic                  pre,
    output logic                  ans,
    output logic                  clear_all,
    output logic                  halt
);

    typedef enum logic [1:0] {KindNormal, KindBranch, KindJalr, KindHalt} kind_e;

    logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;
    kind_e            kind_q [DEPTH];
    kind_e            kind_d [DEPTH];
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       rd_d [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [XLEN-1:0]  imm_d [DEPTH];
    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [XLEN-1:0]  pc_d [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];
    logic [XLEN-1:0]  value_d [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  target_d [DEPTH];
    logic [DEPTH-1:0] pred_q, pred_d, is_c_q, is_c_d;

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head1;
    logic [IDX_W:0]   count_q, count_d;

    logic [1:0]       cm_en_q, cm_en_d;
    logic [4:0]       cm_rd0_q, cm_rd0_d, cm_rd1_q, cm_rd1_d;
    logic [IDX_W-1:0] cm_id0_q, cm_id0_d, cm_id1_q, cm_id1_d;
    logic [XLEN-1:0]  cm_val0_q, cm_val0_d, cm_val1_q, cm_val1_d;
    logic [XLEN-1:0]  pc_next_q, pc_next_d, pc_branch_q, pc_branch_d;
    logic             jalr_q, jalr_d, branch_q, branch_d, pre_q, pre_d, ans_q, ans_d;
    logic             clear_q, clear_d, halt_q, halt_d;

    logic             c0, c1, mispredict, alloc_ok;
    logic [1:0]       n_commit;

    assign head1       = head_q + IDX_W'(1);
    assign rob_full    = (count_q == (IDX_W+1)'(DEPTH));
    assign rob_free_id = tail_q;
    assign rob_head    = head_q;
    assign q1_ready    = valid_q[q1_id] & ready_q[q1_id];
    assign q2_ready    = valid_q[q2_id] & ready_q[q2_id];
    assign q1_value    = q1_ready ? value_q[q1_id] : '0;
    assign q2_value    = q2_ready ? value_q[q2_id] : '0;

    // Slot 1 pairs only two plain instructions so redirects are never mixed with a second commit.
    assign c0 = valid_q[head_q] & ready_q[head_q];
    assign c1 = c0 & valid_q[head1] & ready_q[head1] &
                (kind_q[head_q] == KindNormal) & (kind_q[head1] == KindNormal);
    assign mispredict = c0 & (kind_q[head_q] == KindBranch) &
                        (value_q[head_q][0] != pred_q[head_q]);
    assign alloc_ok   = alloc_valid & ~rob_full & ~mispredict;
    assign n_commit   = c1 ? 2'd2 : (c0 ? 2'd1 : 2'd0);

    always_comb begin
        cm_en_d     = '0;
        cm_rd0_d    = '0;
        cm_rd1_d    = '0;
        cm_id0_d    = '0;
        cm_id1_d    = '0;
        cm_val0_d   = '0;
        cm_val1_d   = '0;
        jalr_d      = 1'b0;
        branch_d    = 1'b0;
        clear_d     = 1'b0;
        pc_next_d   = pc_next_q;
        pc_branch_d = pc_branch_q;
        pre_d       = pre_q;
        ans_d       = ans_q;
        halt_d      = halt_q;
        if (c0) begin
            case (kind_q[head_q])
                KindBranch: begin
                    branch_d    = 1'b1;
                    pc_branch_d = pc_q[head_q];
                    pre_d       = pred_q[head_q];
                    ans_d       = value_q[head_q][0];
                    if (mispredict) begin
                        clear_d   = 1'b1;
                        pc_next_d = value_q[head_q][0] ? pc_q[head_q] + imm_q[head_q] :
                                    pc_q[head_q] + (is_c_q[head_q] ? XLEN'(2) : XLEN'(4));
                    end
                end
                KindJalr: begin
                    jalr_d    = 1'b1;
                    pc_next_d = target_q[head_q];
                end
                KindHalt: halt_d = 1'b1;
                default: ;
            endcase
            if (kind_q[head_q] != KindBranch) begin
                cm_en_d[0] = 1'b1;
                cm_rd0_d   = rd_q[head_q];
                cm_id0_d   = head_q;
                cm_val0_d  = value_q[head_q];
            end
        end
        if (c1) begin
            cm_en_d[1] = 1'b1;
            cm_rd1_d   = rd_q[head1];
            cm_id1_d   = head1;
            cm_val1_d  = value_q[head1];
        end
    end

    always_comb begin
        valid_d  = valid_q;
        ready_d  = ready_q;
        kind_d   = kind_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        value_d  = value_q;
        target_d = target_q;
        pred_d   = pred_q;
        is_c_d   = is_c_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (mispredict) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Ascending port order lets the highest port win on a shared id.
            for (int unsigned p = 0; p < NWB; p++) begin
                if (wb_valid[p] && valid_q[wb_id[p*IDX_W +: IDX_W]]) begin
                    ready_d[wb_id[p*IDX_W +: IDX_W]] = 1'b1;
                    value_d[wb_id[p*IDX_W +: IDX_W]] = wb_value[p*XLEN +: XLEN];
                    if (p == 0) target_d[wb_id[p*IDX_W +: IDX_W]] = wb_target;
                end
            end
            if (c0) begin
                valid_d[head_q] = 1'b0;
                ready_d[head_q] = 1'b0;
            end
            if (c1) begin
                valid_d[head1] = 1'b0;
                ready_d[head1] = 1'b0;
            end
            if (alloc_ok) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                kind_d[tail_q]  = kind_e'(alloc_kind);
                rd_d[tail_q]    = alloc_rd;
                imm_d[tail_q]   = alloc_imm;
                pc_d[tail_q]    = alloc_pc;
                pred_d[tail_q]  = alloc_pred;
                is_c_d[tail_q]  = alloc_is_c;
                tail_d          = tail_q + IDX_W'(1);
            end
            head_d  = head_q + IDX_W'(n_commit);
            count_d = count_q + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(n_commit);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q     <= '0;
            ready_q     <= '0;
            kind_q      <= '{default: KindNormal};
            rd_q        <= '{default: '0};
            imm_q       <= '{default: '0};
            pc_q        <= '{default: '0};
            value_q     <= '{default: '0};
            target_q    <= '{default: '0};
            pred_q      <= '0;
            is_c_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cm_en_q     <= '0;
            cm_rd0_q    <= '0;
            cm_rd1_q    <= '0;
            cm_id0_q    <= '0;
            cm_id1_q    <= '0;
            cm_val0_q   <= '0;
            cm_val1_q   <= '0;
            pc_next_q   <= '0;
            pc_branch_q <= '0;
            jalr_q      <= 1'b0;
            branch_q    <= 1'b0;
            pre_q       <= 1'b0;
            ans_q       <= 1'b0;
            clear_q     <= 1'b0;
            halt_q      <= 1'b0;
        end else if (rdy_in) begin
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            kind_q      <= kind_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            value_q     <= value_d;
            target_q    <= target_d;
            pred_q      <= pred_d;
            is_c_q      <= is_c_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            cm_en_q     <= cm_en_d;
            cm_rd0_q    <= cm_rd0_d;
            cm_rd1_q    <= cm_rd1_d;
            cm_id0_q    <= cm_id0_d;
            cm_id1_q    <= cm_id1_d;
            cm_val0_q   <= cm_val0_d;
            cm_val1_q   <= cm_val1_d;
            pc_next_q   <= pc_next_d;
            pc_branch_q <= pc_branch_d;
            jalr_q      <= jalr_d;
            branch_q    <= branch_d;
            pre_q       <= pre_d;
            ans_q       <= ans_d;
            clear_q     <= clear_d;
            halt_q      <= halt_d;
        end
    end

    assign cm_en         = cm_en_q;
    assign cm_rd0        = cm_rd0_q;
    assign cm_rd1        = cm_rd1_q;
    assign cm_id0        = cm_id0_q;
    assign cm_id1        = cm_id1_q;
    assign cm_val0       = cm_val0_q;
    assign cm_val1       = cm_val1_q;
    assign jalr_finish   = jalr_q;
    assign branch_finish = branch_q;
    assign pc_next       = pc_next_q;
    assign pc_branch     = pc_branch_q;
    assign pre           = pre_q;
    assign ans           = ans_q;
    assign clear_all     = clear_q;
    assign halt          = halt_q;

endmodule

// File: tb/tb_rob_dual_commit.sv
// Bench for rob_dual_commit: directed scenarios plus random traffic, all compared each cycle
// against an entry-array reference model of the buffer.
module tb_rob_dual_commit;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int NWB   = 3;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst_n_in;
    logic              rdy_in;
    logic              alloc_valid;
    logic [1:0]        alloc_kind;
    logic [4:0]        alloc_rd;
    logic [XLEN-1:0]   alloc_imm, alloc_pc;
    logic              alloc_pred, alloc_is_c;
    logic              rob_full;
    logic [IDX_W-1:0]  rob_free_id, rob_head;
    logic [IDX_W-1:0]  q1_id, q2_id;
    logic              q1_ready, q2_ready;
    logic [XLEN-1:0]   q1_value, q2_value;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*IDX_W-1:0] wb_id;
    logic [NWB*XLEN-1:0]  wb_value;
    logic [XLEN-1:0]   wb_target;
    logic [1:0]        cm_en;
    logic [4:0]        cm_rd0, cm_rd1;
    logic [IDX_W-1:0]  cm_id0, cm_id1;
    logic [XLEN-1:0]   cm_val0, cm_val1;
    logic              jalr_finish, branch_finish;
    logic [XLEN-1:0]   pc_next, pc_branch;
    logic              pre, ans, clear_all, halt;

    int checks = 0;
    int failures = 0;

    rob_dual_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NWB(NWB), .XLEN(XLEN)) dut (
        .clk_in(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
        .alloc_imm(alloc_imm), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_is_c(alloc_is_c), .rob_full(rob_full), .rob_free_id(rob_free_id),
        .rob_head(rob_head), .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready),
        .q2_ready(q2_ready), .q1_value(q1_value), .q2_value(q2_value),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_target(wb_target),
        .cm_en(cm_en), .cm_rd0(cm_rd0), .cm_rd1(cm_rd1), .cm_id0(cm_id0), .cm_id1(cm_id1),
        .cm_val0(cm_val0), .cm_val1(cm_val1), .jalr_finish(jalr_finish),
        .branch_finish(branch_finish), .pc_next(pc_next), .pc_branch(pc_branch),
        .pre(pre), .ans(ans), .clear_all(clear_all), .halt(halt)
    );

    always #5 clk = ~clk;

    // Reference model: one record per slot, plus head/tail/count as plain integers.
    bit          m_valid [DEPTH];
    bit          m_ready [DEPTH];
    int          m_kind  [DEPTH];
    logic [4:0]  m_rd    [DEPTH];
    logic [31:0] m_imm [DEPTH], m_pc [DEPTH], m_val [DEPTH], m_tgt [DEPTH];
    bit          m_pred [DEPTH], m_isc [DEPTH];
    int          m_head, m_tail, m_count;

    logic [1:0]  e_cm_en;
    logic [4:0]  e_rd0, e_rd1;
    int          e_id0, e_id1;
    logic [31:0] e_val0, e_val1, e_pcn, e_pcb;
    bit          e_jf, e_bf, e_pre, e_ans, e_clr, e_halt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_ready[i] = 0;
        end
        m_head = 0; m_tail = 0; m_count = 0;
        e_cm_en = 0; e_rd0 = 0; e_rd1 = 0; e_id0 = 0; e_id1 = 0; e_val0 = 0; e_val1 = 0;
        e_pcn = 0; e_pcb = 0; e_jf = 0; e_bf = 0; e_pre = 0; e_ans = 0; e_clr = 0; e_halt = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int h, h1, n, id;
        bit c0, c1, flush;
        if (!rdy_in) return;
        h  = m_head;
        h1 = (m_head + 1) % DEPTH;
        c0 = m_valid[h] && m_ready[h];
        c1 = c0 && m_valid[h1] && m_ready[h1] && m_kind[h] == 0 && m_kind[h1] == 0;
        flush = 0;
        e_cm_en = 0; e_jf = 0; e_bf = 0; e_clr = 0;
        if (c0) begin
            if (m_kind[h] == 1) begin
                e_bf = 1; e_pcb = m_pc[h]; e_pre = m_pred[h]; e_ans = m_val[h][0];
                if (e_ans != e_pre) begin
                    flush = 1;
                    e_clr = 1;
                    e_pcn = e_ans ? m_pc[h] + m_imm[h] : m_pc[h] + (m_isc[h] ? 32'd2 : 32'd4);
                end
            end else begin
                e_cm_en[0] = 1; e_rd0 = m_rd[h]; e_id0 = h; e_val0 = m_val[h];
                if (m_kind[h] == 2) begin
                    e_jf = 1;
                    e_pcn = m_tgt[h];
                end
                if (m_kind[h] == 3) e_halt = 1;
            end
        end
        if (c1) begin
            e_cm_en[1] = 1; e_rd1 = m_rd[h1]; e_id1 = h1; e_val1 = m_val[h1];
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 0;
                m_ready[i] = 0;
            end
            m_head = 0; m_tail = 0; m_count = 0;
        end else begin
            for (int p = 0; p < NWB; p++) begin
                id = int'(wb_id[p*IDX_W +: IDX_W]);
                if (wb_valid[p] && m_valid[id]) begin
                    m_ready[id] = 1;
                    m_val[id] = wb_value[p*XLEN +: XLEN];
                    if (p == 0) m_tgt[id] = wb_target;
                end
            end
            n = 0;
            if (c0) begin m_valid[h] = 0; m_ready[h] = 0; n = 1; end
            if (c1) begin m_valid[h1] = 0; m_ready[h1] = 0; n = 2; end
            if (alloc_valid && m_count < DEPTH) begin
                m_valid[m_tail] = 1; m_ready[m_tail] = 0; m_kind[m_tail] = int'(alloc_kind);
                m_rd[m_tail] = alloc_rd; m_imm[m_tail] = alloc_imm; m_pc[m_tail] = alloc_pc;
                m_pred[m_tail] = alloc_pred; m_isc[m_tail] = alloc_is_c;
                m_tail = (m_tail + 1) % DEPTH;
                m_count++;
            end
            m_count = m_count - n;
            m_head = (m_head + n) % DEPTH;
        end
    endtask

    task automatic check_all();
        bit r1, r2;
        r1 = m_valid[q1_id] && m_ready[q1_id];
        r2 = m_valid[q2_id] && m_ready[q2_id];
        chk("rob_full", rob_full, m_count == DEPTH);
        chk("rob_free_id", rob_free_id, m_tail);
        chk("rob_head", rob_head, m_head);
        chk("q1_ready", q1_ready, r1);
        chk("q1_value", q1_value, r1 ? m_val[q1_id] : 32'd0);
        chk("q2_ready", q2_ready, r2);
        chk("q2_value", q2_value, r2 ? m_val[q2_id] : 32'd0);
        chk("cm_en", cm_en, e_cm_en);
        if (e_cm_en[0]) begin
            chk("cm_rd0", cm_rd0, e_rd0);
            chk("cm_id0", cm_id0, e_id0);
            chk("cm_val0", cm_val0, e_val0);
        end
        if (e_cm_en[1]) begin
            chk("cm_rd1", cm_rd1, e_rd1);
            chk("cm_id1", cm_id1, e_id1);
            chk("cm_val1", cm_val1, e_val1);
        end
        chk("jalr_finish", jalr_finish, e_jf);
        chk("branch_finish", branch_finish, e_bf);
        chk("clear_all", clear_all, e_clr);
        chk("halt", halt, e_halt);
        if (e_jf || e_clr) chk("pc_next", pc_next, e_pcn);
        if (e_bf) begin
            chk("pc_branch", pc_branch, e_pcb);
            chk("pre", pre, e_pre);
            chk("ans", ans, e_ans);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_imm = 0; alloc_pc = 0;
        alloc_pred = 0; alloc_is_c = 0; wb_valid = 0; wb_id = 0; wb_value = 0; wb_target = 0;
    endtask

    // One clock: model advances, DUT clocks, outputs checked on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
        alloc_valid = 0;
        wb_valid = 0;
    endtask

    task automatic alloc(input int kind, input int rd, input logic [31:0] pc,
                         input logic [31:0] imm, input bit pred, input bit isc);
        alloc_valid = 1; alloc_kind = 2'(kind); alloc_rd = 5'(rd);
        alloc_pc = pc; alloc_imm = imm; alloc_pred = pred; alloc_is_c = isc;
    endtask

    task automatic wb(input int p, input int id, input logic [31:0] v);
        wb_valid[p] = 1'b1;
        wb_id[p*IDX_W +: IDX_W] = 3'(id);
        wb_value[p*XLEN +: XLEN] = v;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".rob_full"}, rob_full, 0);
        chk({tag, ".rob_free_id"}, rob_free_id, 0);
        chk({tag, ".rob_head"}, rob_head, 0);
        chk({tag, ".q1_ready"}, q1_ready, 0);
        chk({tag, ".q1_value"}, q1_value, 0);
        chk({tag, ".cm_en"}, cm_en, 0);
        chk({tag, ".cm_val0"}, cm_val0, 0);
        chk({tag, ".pc_next"}, pc_next, 0);
        chk({tag, ".branch_finish"}, branch_finish, 0);
        chk({tag, ".clear_all"}, clear_all, 0);
        chk({tag, ".halt"}, halt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rdy_in = 1;
        rst_n_in = 0;
        model_reset();
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n_in = 1;
        check_all();
    endtask

    initial begin
        rst_n_in = 1; rdy_in = 1; q1_id = 0; q2_id = 0;
        idle_inputs();
        model_reset();
        #2;
        do_reset();

        // Fill to capacity; the ninth allocation is refused.
        for (int i = 0; i < DEPTH; i++) begin
            alloc(0, i + 1, 32'h1000 + 32'(4 * i), 0, 0, 0);
            tick();
        end
        chk("fill.rob_full", rob_full, 1);
        chk("fill.free_id", rob_free_id, 0);
        alloc(0, 9, 32'h2000, 0, 0, 0);
        tick();
        chk("fill9.rob_full", rob_full, 1);
        chk("fill9.head", rob_head, 0);

        // Dual commit of two plain entries written back together.
        do_reset();
        alloc(0, 5, 32'h10, 0, 0, 0); tick();
        alloc(0, 6, 32'h14, 0, 0, 0); tick();
        q1_id = 0; q2_id = 1;
        wb(0, 0, 32'h11); wb(1, 1, 32'h22); tick();
        chk("dual.q1_value", q1_value, 32'h11);
        chk("dual.q2_value", q2_value, 32'h22);
        tick();
        chk("dual.cm_en", cm_en, 2'b11);
        chk("dual.cm_rd0", cm_rd0, 5);
        chk("dual.cm_val0", cm_val0, 32'h11);
        chk("dual.cm_rd1", cm_rd1, 6);
        chk("dual.cm_val1", cm_val1, 32'h22);

        // Branch predicted not-taken but taken; a same-cycle alloc is dropped by the flush.
        do_reset();
        alloc(1, 0, 32'h100, 32'h20, 0, 0); tick();
        alloc(0, 3, 32'h104, 0, 0, 0); tick();
        wb(0, 0, 32'h1); tick();
        alloc(0, 4, 32'h108, 0, 0, 0); tick();
        chk("mp1.branch_finish", branch_finish, 1);
        chk("mp1.ans", ans, 1);
        chk("mp1.pc_next", pc_next, 32'h120);
        chk("mp1.clear_all", clear_all, 1);
        chk("mp1.free_id", rob_free_id, 0);
        tick();
        chk("mp1.clear_drop", clear_all, 0);

        // Compressed branch predicted taken, not taken: fall through by 2.
        alloc(1, 0, 32'h100, 32'h40, 1, 1); tick();
        wb(0, 0, 32'h0); tick();
        tick();
        chk("mp2.pc_next", pc_next, 32'h102);
        chk("mp2.clear_all", clear_all, 1);
        // Correctly predicted branch retires alone; the younger entry commits next cycle.
        alloc(1, 0, 32'h200, 32'h8, 1, 0); tick();
        alloc(0, 7, 32'h204, 0, 0, 0); tick();
        wb(0, 0, 32'h1); wb(1, 1, 32'h33); tick();
        tick();
        chk("bok.branch_finish", branch_finish, 1);
        chk("bok.clear_all", clear_all, 0);
        chk("bok.cm_en", cm_en, 2'b00);
        tick();
        chk("bok.cm_en_next", cm_en, 2'b01);
        chk("bok.cm_rd0", cm_rd0, 7);
        chk("bok.cm_val0", cm_val0, 32'h33);

        // Wrap-around of the tail, then port 2 beats port 0 on a shared id.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(0, i + 1, 32'h300 + 32'(4 * i), 0, 0, 0);
            tick();
        end
        wb(0, 0, 32'hA0); wb(1, 1, 32'hA1); wb(2, 2, 32'hA2); tick();
        wb(0, 3, 32'hA3); wb(1, 4, 32'hA4); wb(2, 5, 32'hA5); tick();
        for (int i = 0; i < 4; i++) tick();
        chk("wrap.head", rob_head, 6);
        for (int i = 0; i < 6; i++) begin
            alloc(0, 10 + i, 32'h400 + 32'(4 * i), 0, 0, 0);
            tick();
        end
        chk("wrap.free_id", rob_free_id, 4);
        q1_id = 1;
        #1;
        chk("wrap.q1_not_ready", q1_ready, 0);
        wb_target = 32'hDEAD;
        wb(0, 1, 32'hAAAA); wb(2, 1, 32'hBBBB); tick();
        chk("wrap.q1_ready", q1_ready, 1);
        chk("wrap.q1_value", q1_value, 32'hBBBB);

        // Jalr redirect, then halt gated by rdy_in.
        do_reset();
        alloc(2, 1, 32'h500, 0, 0, 0); tick();
        alloc(3, 0, 32'h504, 0, 0, 0); tick();
        wb_target = 32'h400;
        wb(0, 0, 32'h55); wb(1, 1, 32'h0); tick();
        tick();
        chk("jalr.cm_en", cm_en, 2'b01);
        chk("jalr.finish", jalr_finish, 1);
        chk("jalr.pc_next", pc_next, 32'h400);
        chk("jalr.cm_val0", cm_val0, 32'h55);
        rdy_in = 0; tick();
        chk("halt.held", halt, 0);
        rdy_in = 1; tick();
        chk("halt.set", halt, 1);
        chk("halt.cm_en", cm_en, 2'b01);
        tick();
        chk("halt.sticky", halt, 1);

        // Random traffic.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            rdy_in = ($urandom_range(0, 9) != 0);
            q1_id = 3'($urandom_range(0, 7));
            q2_id = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 15);
                alloc(r < 11 ? 0 : (r < 14 ? 1 : (r == 14 ? 2 : 3)), $urandom_range(0, 31),
                      $urandom(), $urandom(), $urandom_range(0, 1), $urandom_range(0, 1));
            end
            wb_target = $urandom();
            for (int p = 0; p < NWB; p++)
                if ($urandom_range(0, 9) < 4) wb(p, $urandom_range(0, 7), $urandom());
            tick();
        end

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        alloc(0, 2, 32'h600, 0, 0, 0); tick();
        #2;
        rst_n_in = 0;
        model_reset();
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst_n_in = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_dual_commit.md
Name: rob_dual_commit

Overview:
- Parametrised reorder buffer for the out-of-order core; successor of the single-commit ROB.
- Sits between decoder (allocation), RS/LSB (writeback over NWB ports) and regfile/ifetch (commit, redirect).
- Adds configurable depth, an explicit occupancy counter (unambiguous full/empty), and up to two in-order commits per cycle.

Parameters:
DEPTH, 8, entries; power of two, >=4
IDX_W, 3, log2(DEPTH)
NWB, 3, writeback ports (0=ALU, 1=load, 2=store)
XLEN, 32, data/pc width

Ports:
clk_in  in  1  clock
rst_n_in  in  1  async active-low reset
rdy_in  in  1  0 = hold all state
alloc_valid  in  1  allocate at tail
alloc_kind  in  2  0 normal, 1 branch, 2 jalr, 3 halt
alloc_rd  in  5  dest reg (0 = none)
alloc_imm, alloc_pc  in  XLEN  branch offset, inst pc
alloc_pred, alloc_is_c  in  1  predicted taken; compressed inst
rob_full  out  1  count==DEPTH
rob_free_id  out  IDX_W  tail index
rob_head  out  IDX_W  head index
q1_id, q2_id  in  IDX_W  operand lookup
q1_ready, q2_ready  out  1  entry written back
q1_value, q2_value  out  XLEN  value if ready, else 0
wb_valid  in  NWB  per-port writeback strobe
wb_id  in  NWB*IDX_W  flattened entry ids
wb_value  in  NWB*XLEN  flattened values
wb_target  in  XLEN  jalr target, port 0 only
cm_en  out  2  commit slot strobes
cm_rd0, cm_rd1  out  5  commit dest
cm_id0, cm_id1  out  IDX_W  committing entry
cm_val0, cm_val1  out  XLEN  commit value
jalr_finish, branch_finish  out  1  one-cycle pulses
pc_next, pc_branch  out  XLEN  redirect target; branch pc
pre, ans  out  1  predicted / actual taken
clear_all  out  1  flush pulse
halt  out  1  sticky

Behaviour:
- Reset (async, rst_n_in=0): head=tail=count=0, all entries invalid/not-ready; all outputs 0. Mid-operation reset discards everything immediately.
- rdy_in=0: no state change; registered outputs hold.
- Allocation (alloc_valid, not full, no flush this cycle): entry[tail] valid, not-ready, fields latched; tail wraps DEPTH-1 -> 0. Alloc while full: ignored.
- Writeback: port p strobe sets ready[id]=1, value[id]; port 0 also latches target. Ports to distinct ids all apply; same id on two ports: highest port index wins. Writeback to invalid entry ignored.
- Queries: combinational on registered state; no same-cycle writeback bypass.
- Commit slot 0: head valid and ready. Slot 1: slot 0 commits, head+1 valid and ready, neither entry kind!=0. cm_* registered, 1 cycle after decision; cm_rd=0 entries still pulse cm_en (regfile ignores x0).
- count_next = count + alloc_accepted - commits; head advances by commits, wraps.
- Branch at head: branch_finish=1, pc_branch=pc, pre=pred, ans=value[0]. If ans!=pre: pc_next = ans ? pc+imm : pc+(is_c?2:4); flush; branch not reported in cm_en.
- Flush: all entries invalid, head=tail=count=0 next cycle, clear_all pulses 1 cycle; same-cycle alloc and writebacks dropped.
- Jalr at head: commits rd value, jalr_finish=1, pc_next=target.
- Halt at head: commits, halt=1 sticky until reset.
- Pulses deassert next cycle absent new event. Adders modulo 2^XLEN.

Test Plan:
- Reset then 8 allocs (DEPTH=8) -> rob_full=1 after 8th, rob_free_id=0; 9th alloc ignored, count stays 8.
- Alloc ids 0,1 (normal, rd 5,6); wb both same cycle values 0x11,0x22 -> next cycle cm_en=2'b11, cm_rd0=5, cm_val0=0x11, cm_rd1=6, cm_val1=0x22.
- Branch pc=0x100, imm=0x20, pred=0, wb value 1 -> branch_finish=1, ans=1, pc_next=0x120, clear_all=1; next cycle count=0, head=tail=0.
- Branch pred=1, is_c=1, wb 0 -> pc_next=0x102, flush; branch pred=1 resolved 1 -> no flush, younger normal commits following cycle only (no dual with branch).
- Fill to wrap: commit 6, alloc 6 -> tail wraps to 4, q1 on wrapped id returns value after wb; ports 0 and 2 to same id -> value from port 2.
- Halt at head with rdy_in toggling -> halt asserts only on rdy_in=1 cycle; rst_n_in low mid-stream -> all outputs 0 immediately.
